// File: rtl/hazard_pkg.sv
// Shared constants and FSM state type for the pipeline hazard controller.
package hazard_pkg;
  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} hz_state_t;
endpackage

// File: rtl/hazard_if.sv
// Datapath <-> hazard controller bundle. HAZARD_PERF_EN adds the perf counter outputs.
interface hazard_if;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, RegWriteM, RegWriteW, MemReqM, dmem_ready;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       mem_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flushes, perf_aborts;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE, PCSrcE,
           RegWriteM, RegWriteW, MemReqM, dmem_ready,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, mem_err,
           perf_stall_cycles, perf_flushes, perf_aborts
  );
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE, PCSrcE,
           RegWriteM, RegWriteW, MemReqM, dmem_ready,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, mem_err,
           perf_stall_cycles, perf_flushes, perf_aborts
  );
`else
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE, PCSrcE,
           RegWriteM, RegWriteW, MemReqM, dmem_ready,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, mem_err
  );
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE, PCSrcE,
           RegWriteM, RegWriteW, MemReqM, dmem_ready,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, mem_err
  );
`endif
endinterface

// File: rtl/hazard_fwd_sel.sv
// Single-operand EX forwarding select; the MEM stage has the newer value so it wins.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       regwrite_m,
  input  logic [4:0] rd_w,
  input  logic       regwrite_w,
  output logic [1:0] fwd
);
  always_comb begin
    fwd = FWD_RF;
    if (regwrite_m && rd_m != 5'd0 && rd_m == rs)      fwd = FWD_MEM;
    else if (regwrite_w && rd_w != 5'd0 && rd_w == rs) fwd = FWD_WB;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control plus memory-wait watchdog for the five-stage core.
// Defining HAZARD_PERF_EN adds stall/flush/abort perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input logic   clk,
  input logic   reset,
  hazard_if.slave hz
);
  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  hz_state_t  state, state_nx;
  logic [7:0] wait_cnt, cnt_nx;
  logic       mem_err_q;
  logic       abort, mem_stall, lw_stall;

  fwd_sel u_fwd_a (.rs(hz.Rs1E), .rd_m(hz.RdM), .regwrite_m(hz.RegWriteM),
                   .rd_w(hz.RdW), .regwrite_w(hz.RegWriteW), .fwd(hz.ForwardAE));
  fwd_sel u_fwd_b (.rs(hz.Rs2E), .rd_m(hz.RdM), .regwrite_m(hz.RegWriteM),
                   .rd_w(hz.RdW), .regwrite_w(hz.RegWriteW), .fwd(hz.ForwardBE));

  assign abort     = (state == WAIT) && (wait_cnt == TMO) && !hz.dmem_ready;
  assign mem_stall = hz.MemReqM && !hz.dmem_ready && !abort;
  assign lw_stall  = (hz.ResultSrcE == RESULT_LOAD) && (hz.RdE != 5'd0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= cnt_nx;
      if (abort) mem_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = wait_cnt;
    case (state)
      RUN: if (mem_stall) begin
        state_nx = WAIT;
        cnt_nx   = 8'd1;
      end
      WAIT: if (abort || hz.dmem_ready || !hz.MemReqM) begin
        state_nx = RUN;
        cnt_nx   = 8'd0;
      end else begin
        cnt_nx   = wait_cnt + 8'd1;
      end
      default: begin
        state_nx = RUN;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  // A frozen EX means a branch resolved there cannot be acted on yet.
  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    hz.FlushW = mem_stall || abort;
    if (mem_stall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
    end else if (hz.PCSrcE) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (lw_stall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
    end
  end

  assign hz.mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q, flush_q, abort_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
      abort_q <= 32'd0;
    end else begin
      if (hz.StallF)                stall_q <= stall_q + 32'd1;
      if (hz.PCSrcE && !mem_stall) flush_q <= flush_q + 32'd1;
      if (abort)                    abort_q <= abort_q + 32'd1;
    end
  end
  assign hz.perf_stall_cycles = stall_q;
  assign hz.perf_flushes      = flush_q;
  assign hz.perf_aborts       = abort_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios plus randomized run against a rule-level model of the hazard controller.
module tb_hazard_ctrl;
  import hazard_pkg::*;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  hazard_if hz();
  hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .hz(hz));

  always #5 clk = ~clk;

  // Model state: stall cycles already spent on the current access, sticky error.
  int   m_stalled;
  logic m_err;
  int   m_pstall, m_pflush, m_pabort;

  function automatic logic [11:0] obs();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE,
            hz.FlushW, hz.ForwardAE, hz.ForwardBE, hz.mem_err};
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs) return 2'b10;
    if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_abort();
    return (m_stalled == TMO) && !hz.dmem_ready;
  endfunction

  function automatic logic [11:0] model_out();
    logic ab, ms, lw;
    logic [3:0] st;
    logic fd, fe;
    ab = m_abort();
    ms = hz.MemReqM && !hz.dmem_ready && !ab;
    lw = hz.ResultSrcE == 2'b01 && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    st = 4'b0000; fd = 1'b0; fe = 1'b0;
    if (ms)             st = 4'b1111;
    else if (hz.PCSrcE) begin fd = 1'b1; fe = 1'b1; end
    else if (lw)        begin st = 4'b1100; fe = 1'b1; end
    return {st, fd, fe, ms || ab, m_fwd(hz.Rs1E), m_fwd(hz.Rs2E), m_err};
  endfunction

  task automatic clear_inputs();
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0;
    hz.RdM = 0; hz.RdW = 0; hz.ResultSrcE = 0; hz.PCSrcE = 0;
    hz.RegWriteM = 0; hz.RegWriteW = 0; hz.MemReqM = 0; hz.dmem_ready = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++;
    if (obs() !== 12'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", obs(), 12'b0);
    end
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_forwarding();
    hz.RdM = 5; hz.RegWriteM = 1; hz.RdW = 5; hz.RegWriteW = 1; hz.Rs1E = 5;
    @(negedge clk); checks++;
    if (hz.ForwardAE !== 2'b10) begin
      errors++; $display("FAIL fwd_mem: got %b want 10", hz.ForwardAE);
    end
    hz.RdM = 0;
    @(negedge clk); checks++;
    if (hz.ForwardAE !== 2'b01) begin
      errors++; $display("FAIL fwd_wb: got %b want 01", hz.ForwardAE);
    end
    hz.Rs1E = 0;
    @(negedge clk); checks++;
    if (hz.ForwardAE !== 2'b00) begin
      errors++; $display("FAIL fwd_x0: got %b want 00", hz.ForwardAE);
    end
    hz.RdM = 9; hz.Rs2E = 9; hz.RegWriteM = 0; hz.RdW = 9;
    @(negedge clk); checks++;
    if (hz.ForwardBE !== 2'b01) begin
      errors++; $display("FAIL fwd_b_nowrite_m: got %b want 01", hz.ForwardBE);
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_load_use();
    hz.ResultSrcE = RESULT_LOAD; hz.RdE = 7; hz.Rs2D = 7;
    @(negedge clk); checks++;
    if ({hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE} !== 5'b11001) begin
      errors++; $display("FAIL load_use_stall: got %b want 11001",
                         {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE});
    end
    next_cycle();
    hz.ResultSrcE = 2'b00; hz.RdE = 0;  // bubble now in EX
    @(negedge clk); checks++;
    if ({hz.StallF, hz.StallD, hz.FlushE} !== 3'b000) begin
      errors++; $display("FAIL load_use_release: got %b want 000",
                         {hz.StallF, hz.StallD, hz.FlushE});
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_branch();
    hz.ResultSrcE = RESULT_LOAD; hz.RdE = 7; hz.Rs1D = 7; hz.PCSrcE = 1;
    @(negedge clk); checks++;
    if ({hz.FlushD, hz.FlushE, hz.StallF, hz.StallD} !== 4'b1100) begin
      errors++; $display("FAIL branch_over_lw: got %b want 1100",
                         {hz.FlushD, hz.FlushE, hz.StallF, hz.StallD});
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_mem_wait();
    hz.MemReqM = 1; hz.dmem_ready = 0;
    for (int c = 0; c < 3; c++) begin
      hz.PCSrcE = (c == 1);
      @(negedge clk); checks++;
      if ({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW, hz.FlushD, hz.FlushE} !== 7'b1111100) begin
        errors++; $display("FAIL mem_wait_c%0d: got %b want 1111100", c,
          {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW, hz.FlushD, hz.FlushE});
      end
      next_cycle();
    end
    hz.PCSrcE = 0; hz.dmem_ready = 1;
    @(negedge clk); checks++;
    if ({hz.StallF, hz.StallM, hz.FlushW, hz.mem_err} !== 4'b0000) begin
      errors++; $display("FAIL mem_wait_done: got %b want 0000",
                         {hz.StallF, hz.StallM, hz.FlushW, hz.mem_err});
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_watchdog();
    hz.MemReqM = 1; hz.dmem_ready = 0;
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk); checks++;
      if ({hz.StallF, hz.StallM, hz.FlushW} !== 3'b111) begin
        errors++; $display("FAIL wd_stall_c%0d: got %b want 111", c, {hz.StallF, hz.StallM, hz.FlushW});
      end
      next_cycle();
    end
    @(negedge clk); checks++;
    if ({hz.StallF, hz.StallM, hz.FlushW, hz.mem_err} !== 4'b0010) begin
      errors++; $display("FAIL wd_abort: got %b want 0010", {hz.StallF, hz.StallM, hz.FlushW, hz.mem_err});
    end
    next_cycle();
    hz.MemReqM = 0;
    @(negedge clk); checks++;
    if ({hz.mem_err, hz.StallF, hz.FlushW} !== 3'b100) begin
      errors++; $display("FAIL wd_err_set: got %b want 100", {hz.mem_err, hz.StallF, hz.FlushW});
    end
    next_cycle();
    // Start a new access, then reset mid-WAIT.
    hz.MemReqM = 1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1; checks++;
    if (hz.mem_err !== 1'b0) begin
      errors++; $display("FAIL wd_async_reset_err: got %b want 0", hz.mem_err);
    end
    @(negedge clk);
    reset = 1'b1;
    // Fresh count after reset: full TMO stall cycles before the next abort.
    for (int c = 1; c < TMO; c++) begin
      next_cycle();
      @(negedge clk); checks++;
      if (hz.StallM !== 1'b1) begin
        errors++; $display("FAIL wd_post_reset_c%0d: got %b want 1", c, hz.StallM);
      end
    end
    next_cycle();
    @(negedge clk); checks++;
    if ({hz.StallM, hz.FlushW} !== 2'b01) begin
      errors++; $display("FAIL wd_post_reset_abort: got %b want 01", {hz.StallM, hz.FlushW});
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_random();
    logic [11:0] exp_v;
    logic ab, ms;
    do_reset();
    m_stalled = 0; m_err = 1'b0;
    m_pstall = 0; m_pflush = 0; m_pabort = 0;
    for (int i = 0; i < 1500; i++) begin
      hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
      hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
      hz.RdE  = 5'($urandom_range(0, 3)); hz.RdM  = 5'($urandom_range(0, 3));
      hz.RdW  = 5'($urandom_range(0, 3));
      hz.ResultSrcE = 2'($urandom_range(0, 3));
      hz.RegWriteM = 1'($urandom_range(0, 1)); hz.RegWriteW = 1'($urandom_range(0, 1));
      hz.PCSrcE = ($urandom_range(0, 7) == 0);
      hz.MemReqM = (m_stalled > 0) ? ($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 1));
      hz.dmem_ready = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      exp_v = model_out();
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL rand_cycle%0d: got %b want %b", i, obs(), exp_v);
      end
      ab = m_abort();
      ms = hz.MemReqM && !hz.dmem_ready && !ab;
      if (exp_v[11]) m_pstall++;
      if (hz.PCSrcE && !ms) m_pflush++;
      if (ab) begin m_stalled = 0; m_err = 1'b1; m_pabort++; end
      else if (ms) m_stalled++;
      else m_stalled = 0;
      next_cycle();
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if ({hz.perf_stall_cycles, hz.perf_flushes, hz.perf_aborts} !==
        {32'(m_pstall), 32'(m_pflush), 32'(m_pabort)}) begin
      errors++; $display("FAIL perf_counters: got %0d/%0d/%0d want %0d/%0d/%0d",
        hz.perf_stall_cycles, hz.perf_flushes, hz.perf_aborts, m_pstall, m_pflush, m_pabort);
    end
`endif
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_watchdog();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage core. It drives the stall and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and generates EX-stage forwarding selects. It also sequences multi-cycle data-memory accesses through a ready handshake, with a bounded-wait watchdog. It sits beside the datapath and holds no datapath state.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 16: maximum consecutive stall cycles allowed for one memory access before it is aborted; legal range 1..255.

Ports:
- `clk` in 1: core clock.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `Rs1D`, `Rs2D` in 5 each: source registers of the instruction in ID.
- `Rs1E`, `Rs2E`, `RdE` in 5 each: source and destination registers of the instruction in EX.
- `ResultSrcE` in 2: `2'b01` marks a load in EX.
- `PCSrcE` in 1: branch taken or jump, resolved in EX.
- `RdM` in 5, `RegWriteM` in 1: MEM-stage writeback info.
- `RdW` in 5, `RegWriteW` in 1: WB-stage writeback info.
- `MemReqM` in 1: a load or store occupies MEM.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `StallF`, `StallD`, `StallE`, `StallM` out 1 each: hold the corresponding pipeline register.
- `FlushD`, `FlushE`, `FlushW` out 1 each: load a bubble into IF/ID, ID/EX or MEM/WB.
- `ForwardAE`, `ForwardBE` out 2 each: `00` = register file, `10` = MEM result, `01` = WB result.
- `mem_err` out 1: sticky flag, set when an access is aborted by the watchdog.

## Operation
- **Forwarding** (combinational, per operand):
  - `10` when `RegWriteM`, `RdM != 0` and `RdM == RsxE`.
  - Otherwise `01` when `RegWriteW`, `RdW != 0` and `RdW == RsxE`.
  - Otherwise `00`.
  - MEM wins over WB.
- **lw_stall** = `ResultSrcE == 01`, `RdE != 0`, and `RdE` equals `Rs1D` or `Rs2D`.
- **mem_stall** = `MemReqM && !dmem_ready && !abort`.
- **FSM** with states RUN and WAIT, plus counter `wait_cnt`:
  - RUN → WAIT when mem_stall; `wait_cnt` becomes 1.
  - In WAIT, `wait_cnt` increments each cycle mem_stall holds.
  - WAIT → RUN when `dmem_ready` or `!MemReqM`; `wait_cnt` clears to 0.
  - **abort** = state WAIT and `wait_cnt == MEM_TIMEOUT` and `!dmem_ready`.
  - On abort: no stall, `FlushW = 1`, `mem_err` is set at the next edge, and the FSM returns to RUN with `wait_cnt = 0`.
- **Priority**, highest first:
  1. mem_stall: `StallF`, `StallD`, `StallE` and `StallM` = 1; `FlushW` = 1; `FlushD` and `FlushE` are forced to 0, and `PCSrcE` is ignored because EX is frozen.
  2. `PCSrcE`: `FlushD` = 1 and `FlushE` = 1, with no stall. A simultaneous lw_stall is discarded because the ID instruction is wrong-path.
  3. lw_stall: `StallF` = 1, `StallD` = 1, `FlushE` = 1.
- `mem_err` is cleared only by reset.

## Timing
- All stall, flush and forward outputs are combinational from inputs and current state, valid in the same cycle. There are no registered outputs except `mem_err`.
- lw_stall lasts exactly 1 cycle, because the bubble placed in EX clears the condition.
- A memory access sees at most `MEM_TIMEOUT` stall cycles. The abort happens in cycle `MEM_TIMEOUT + 1` of the wait.
- If `dmem_ready` is high in the first cycle of an access, there are no stall cycles and the FSM stays in RUN.
- Back-to-back accesses: a new `MemReqM` in the cycle after completion starts a fresh count from 0.
- Reset (asserted at any time, including mid-WAIT): state = RUN, `wait_cnt` = 0, `mem_err` = 0, perf counters = 0. The outputs then follow the combinational rules using these values.

## Configuration
- **`HAZARD_PERF_EN` defined:** adds three 32-bit wrapping output counters:
  - `perf_stall_cycles`: counts cycles with `StallF` = 1.
  - `perf_flushes`: counts cycles with `PCSrcE` flushing.
  - `perf_aborts`: counts watchdog aborts.
- Counters clear on reset.
- **`HAZARD_PERF_EN` undefined:** these ports and the counter logic are absent; all other behaviour is identical.

## Structure
- **Shared package `hazard_pkg`:**
  - Forward-select constants `FWD_RF` = 00, `FWD_WB` = 01, `FWD_MEM` = 10.
  - `RESULT_LOAD` = `2'b01`.
  - FSM state enum `RUN` / `WAIT`.
- **One sub-module, `fwd_sel`:** the single-operand forwarding comparator, instantiated twice.

## Test plan
- **Forwarding:** `RdM` = 5 with `RegWriteM`, `RdW` = 5 with `RegWriteW`, `Rs1E` = 5 → `ForwardAE` = `10`. With `RdM` = 0 instead → `01`. With `Rs1E` = 0 → `00`.
- **Load-use:** `ResultSrcE` = `01`, `RdE` = 7, `Rs2D` = 7 → exactly one cycle of `StallF` = `StallD` = `FlushE` = 1.
- **Branch:** `PCSrcE` = 1 together with the load-use condition → `FlushD` = `FlushE` = 1, and `StallF` = `StallD` = 0.
- **Memory wait:** `MemReqM` = 1 with `dmem_ready` low for 3 cycles, then high → 3 cycles of all stalls plus `FlushW`, 0 on the fourth cycle, and `mem_err` = 0.
- **Watchdog:** `MEM_TIMEOUT` = 4 and `dmem_ready` held low → 4 stall cycles, then in the 5th cycle stall = 0 and `FlushW` = 1; `mem_err` = 1 from the next edge. Asserting `reset` low mid-WAIT returns state to RUN and clears `mem_err` asynchronously.
